// File: rtl/sipo_deserializer.sv
// sipo_deserializer
// Serial-to-parallel receiver. A start strobe (qualified by sin_valid) aligns a
// frame, WIDTH valid bits are collected in a shift register, and the completed
// word is handed to a one-deep output buffer with a valid/ready handshake.
// A completed word that finds the buffer full and not draining is dropped and
// the sticky overrun flag is raised.
//
// Ports
//   clk, rst_n       rising-edge clock, asynchronous active-low reset
//   sin, sin_valid   serial bit and its qualifier
//   start            frame alignment strobe (only honoured with sin_valid)
//   dout, dout_valid received word, held stable until accepted
//   dout_ready       consumer accepts dout on dout_valid && dout_ready
//   busy             high while a frame is being collected
//   bit_cnt          bits received so far in the current frame
//   overrun          sticky drop flag, cleared by clr_ovr (a new drop wins)
module sipo_deserializer #(
    parameter int WIDTH      = 4,
    parameter bit MSB_FIRST  = 1'b1,
    parameter bit CONTINUOUS = 1'b0,
    localparam int CW        = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sin,
    input  logic             sin_valid,
    input  logic             start,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             busy,
    output logic [CW-1:0]    bit_cnt,
    output logic             overrun,
    input  logic             clr_ovr
);

    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             dout_valid_q, dout_valid_d;
    logic             overrun_q, overrun_d;

    logic             take_bit;
    logic             done;
    logic             buf_free;
    logic [WIDTH-1:0] base;
    logic [WIDTH-1:0] shifted;
    logic [CW-1:0]    cnt_inc;

    // A start bit (in either state) restarts the frame from an empty word,
    // which covers both the idle start and the resync case.
    always_comb begin
        take_bit = sin_valid && (start || (state_q == SHIFT));
        base     = start ? '0 : shift_q;
        cnt_inc  = (start ? '0 : cnt_q) + CW'(1);
        if (MSB_FIRST) shifted = {base[WIDTH-2:0], sin};
        else           shifted = {sin, base[WIDTH-1:1]};
        done     = take_bit && (cnt_inc == CW'(WIDTH));
        // The buffer can take a new word if empty or being drained this edge.
        buf_free = !dout_valid_q || dout_ready;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (done)          state_d = CONTINUOUS ? SHIFT : IDLE;
        else if (take_bit) state_d = SHIFT;
    end

    // Output logic
    always_comb begin
        busy = (state_q == SHIFT);
    end

    // Datapath next values
    always_comb begin
        shift_d      = shift_q;
        cnt_d        = cnt_q;
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
        overrun_d    = overrun_q;

        if (done) begin
            shift_d = '0;
            cnt_d   = '0;
        end else if (take_bit) begin
            shift_d = shifted;
            cnt_d   = cnt_inc;
        end

        if (done && buf_free) begin
            dout_d       = shifted;
            dout_valid_d = 1'b1;
        end else if (dout_valid_q && dout_ready) begin
            dout_valid_d = 1'b0;
        end

        // Set has priority over clear.
        if (done && !buf_free) overrun_d = 1'b1;
        else if (clr_ovr)      overrun_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q      <= '0;
            cnt_q        <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            shift_q      <= shift_d;
            cnt_q        <= cnt_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            overrun_q    <= overrun_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign bit_cnt    = cnt_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_sipo_deserializer.sv
// tb_sipo_deserializer
// Three instances share one stimulus stream: MSB-first single-frame, LSB-first
// single-frame, and MSB-first continuous. A directed table exercises the basic
// framing, gaps, resync and overrun on the single-frame instances, hand-written
// sequences cover the continuous-mode and reset corner cases, and a random
// phase compares every instance against a frame-level reference model.
module tb_sipo_deserializer;

    localparam int W  = 4;
    localparam int CW = $clog2(W) + 1;

    logic clk = 1'b0;
    logic rst_n, sin, sin_valid, start, dout_ready, clr_ovr;

    logic [W-1:0]  a_dout [3];
    logic          a_vld  [3];
    logic          a_busy [3];
    logic [CW-1:0] a_cnt  [3];
    logic          a_ovr  [3];

    always #5 clk = ~clk;

    sipo_deserializer #(.WIDTH(W), .MSB_FIRST(1'b1), .CONTINUOUS(1'b0)) u_msb (
        .clk(clk), .rst_n(rst_n), .sin(sin), .sin_valid(sin_valid), .start(start),
        .dout(a_dout[0]), .dout_valid(a_vld[0]), .dout_ready(dout_ready),
        .busy(a_busy[0]), .bit_cnt(a_cnt[0]), .overrun(a_ovr[0]), .clr_ovr(clr_ovr));

    sipo_deserializer #(.WIDTH(W), .MSB_FIRST(1'b0), .CONTINUOUS(1'b0)) u_lsb (
        .clk(clk), .rst_n(rst_n), .sin(sin), .sin_valid(sin_valid), .start(start),
        .dout(a_dout[1]), .dout_valid(a_vld[1]), .dout_ready(dout_ready),
        .busy(a_busy[1]), .bit_cnt(a_cnt[1]), .overrun(a_ovr[1]), .clr_ovr(clr_ovr));

    sipo_deserializer #(.WIDTH(W), .MSB_FIRST(1'b1), .CONTINUOUS(1'b1)) u_cont (
        .clk(clk), .rst_n(rst_n), .sin(sin), .sin_valid(sin_valid), .start(start),
        .dout(a_dout[2]), .dout_valid(a_vld[2]), .dout_ready(dout_ready),
        .busy(a_busy[2]), .bit_cnt(a_cnt[2]), .overrun(a_ovr[2]), .clr_ovr(clr_ovr));

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (frame level) ----------------
    bit           m_msb  [3] = '{1'b1, 1'b0, 1'b1};
    bit           m_cont [3] = '{1'b0, 1'b0, 1'b1};
    bit           m_bits [3][W];
    int           m_cnt  [3];
    bit           m_inframe [3];
    logic [W-1:0] m_dout [3];
    bit           m_vld  [3];
    bit           m_ovr  [3];

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_cnt[i] = 0; m_inframe[i] = 0; m_dout[i] = '0; m_vld[i] = 0; m_ovr[i] = 0;
        end
    endtask

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic model_step();
        for (int i = 0; i < 3; i++) begin
            bit xfer = 0, drop = 0;
            logic [W-1:0] word = '0;
            if (sin_valid && (start || m_inframe[i])) begin
                if (start) m_cnt[i] = 0;
                m_bits[i][m_cnt[i]] = sin;
                m_cnt[i]++;
                m_inframe[i] = 1;
                if (m_cnt[i] == W) begin
                    for (int k = 0; k < W; k++)
                        if (m_msb[i]) word[W-1-k] = m_bits[i][k];
                        else          word[k]     = m_bits[i][k];
                    if (!m_vld[i] || dout_ready) xfer = 1; else drop = 1;
                    m_cnt[i] = 0;
                    m_inframe[i] = m_cont[i];
                end
            end
            if (xfer) begin m_dout[i] = word; m_vld[i] = 1; end
            else if (m_vld[i] && dout_ready) m_vld[i] = 0;
            if (drop) m_ovr[i] = 1;
            else if (clr_ovr) m_ovr[i] = 0;
        end
    endtask

    task automatic model_check();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("model_dout[%0d]", i),  32'(a_dout[i]), 32'(m_dout[i]));
            chk($sformatf("model_vld[%0d]", i),   32'(a_vld[i]),  32'(m_vld[i]));
            chk($sformatf("model_busy[%0d]", i),  32'(a_busy[i]), 32'(m_inframe[i]));
            chk($sformatf("model_cnt[%0d]", i),   32'(a_cnt[i]),  32'(m_cnt[i]));
            chk($sformatf("model_ovr[%0d]", i),   32'(a_ovr[i]),  32'(m_ovr[i]));
        end
    endtask

    // One clock: model follows the applied inputs, outputs sampled 1 after the edge.
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        model_check();
    endtask

    task automatic drive(input bit st, input bit sv, input bit s, input bit rdy, input bit clr);
        start = st; sin_valid = sv; sin = s; dout_ready = rdy; clr_ovr = clr;
        tick();
    endtask

    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        model_reset();
        #3;
        rst_n = 1'b1;
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        bit st, sv, s, rdy, clr;
        logic [3:0] dm; bit vm;   // expected on MSB-first instance
        logic [3:0] dl; bit vl;   // expected on LSB-first instance
        bit busy; int cnt; bit ovr;
    } vec_t;

    vec_t tbl[20];

    initial begin
        //           st sv s rdy clr   dm  vm  dl  vl busy cnt ovr
        tbl[0]  = '{1, 1, 1, 1, 0, 4'h0, 0, 4'h0, 0, 1, 1, 0};
        tbl[1]  = '{0, 1, 0, 1, 0, 4'h0, 0, 4'h0, 0, 1, 2, 0};
        tbl[2]  = '{0, 0, 0, 1, 0, 4'h0, 0, 4'h0, 0, 1, 2, 0};
        tbl[3]  = '{0, 0, 1, 1, 0, 4'h0, 0, 4'h0, 0, 1, 2, 0};
        tbl[4]  = '{0, 1, 1, 1, 0, 4'h0, 0, 4'h0, 0, 1, 3, 0};
        tbl[5]  = '{0, 1, 1, 1, 0, 4'hB, 1, 4'hD, 1, 0, 0, 0};
        tbl[6]  = '{0, 0, 0, 1, 0, 4'hB, 0, 4'hD, 0, 0, 0, 0};
        tbl[7]  = '{0, 1, 1, 1, 0, 4'hB, 0, 4'hD, 0, 0, 0, 0};
        tbl[8]  = '{1, 1, 1, 1, 0, 4'hB, 0, 4'hD, 0, 1, 1, 0};
        tbl[9]  = '{0, 1, 0, 1, 0, 4'hB, 0, 4'hD, 0, 1, 2, 0};
        tbl[10] = '{1, 1, 0, 1, 0, 4'hB, 0, 4'hD, 0, 1, 1, 0};
        tbl[11] = '{0, 1, 1, 1, 0, 4'hB, 0, 4'hD, 0, 1, 2, 0};
        tbl[12] = '{0, 1, 1, 1, 0, 4'hB, 0, 4'hD, 0, 1, 3, 0};
        tbl[13] = '{0, 1, 0, 1, 0, 4'h6, 1, 4'h6, 1, 0, 0, 0};
        tbl[14] = '{0, 0, 0, 0, 0, 4'h6, 1, 4'h6, 1, 0, 0, 0};
        tbl[15] = '{1, 1, 0, 0, 0, 4'h6, 1, 4'h6, 1, 1, 1, 0};
        tbl[16] = '{0, 1, 0, 0, 0, 4'h6, 1, 4'h6, 1, 1, 2, 0};
        tbl[17] = '{0, 1, 0, 0, 0, 4'h6, 1, 4'h6, 1, 1, 3, 0};
        tbl[18] = '{0, 1, 1, 0, 0, 4'h6, 1, 4'h6, 1, 0, 0, 1};
        tbl[19] = '{0, 0, 0, 1, 1, 4'h6, 0, 4'h6, 0, 0, 0, 0};
    end

    // ---------------- main sequence ----------------
    initial begin
        rst_n = 1'b0; sin = 0; sin_valid = 0; start = 0; dout_ready = 0; clr_ovr = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("reset_dout[%0d]", i), 32'(a_dout[i]), 0);
            chk($sformatf("reset_vld[%0d]", i),  32'(a_vld[i]),  0);
            chk($sformatf("reset_busy[%0d]", i), 32'(a_busy[i]), 0);
            chk($sformatf("reset_cnt[%0d]", i),  32'(a_cnt[i]),  0);
            chk($sformatf("reset_ovr[%0d]", i),  32'(a_ovr[i]),  0);
        end
        rst_n = 1'b1;

        // Directed table on the single-frame instances
        for (int r = 0; r < 20; r++) begin
            drive(tbl[r].st, tbl[r].sv, tbl[r].s, tbl[r].rdy, tbl[r].clr);
            chk($sformatf("tbl%0d_dout_msb", r), 32'(a_dout[0]), 32'(tbl[r].dm));
            chk($sformatf("tbl%0d_vld_msb", r),  32'(a_vld[0]),  32'(tbl[r].vm));
            chk($sformatf("tbl%0d_dout_lsb", r), 32'(a_dout[1]), 32'(tbl[r].dl));
            chk($sformatf("tbl%0d_vld_lsb", r),  32'(a_vld[1]),  32'(tbl[r].vl));
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("tbl%0d_busy[%0d]", r, i), 32'(a_busy[i]), 32'(tbl[r].busy));
                chk($sformatf("tbl%0d_cnt[%0d]", r, i),  32'(a_cnt[i]),  32'(tbl[r].cnt));
                chk($sformatf("tbl%0d_ovr[%0d]", r, i),  32'(a_ovr[i]),  32'(tbl[r].ovr));
            end
        end

        // Continuous mode: backpressure drop, clear, then accept+complete same edge
        do_reset();
        drive(1, 1, 1, 0, 0); drive(0, 1, 0, 0, 0); drive(0, 1, 1, 0, 0); drive(0, 1, 0, 0, 0);
        chk("cont_first_dout", 32'(a_dout[2]), 32'hA);
        chk("cont_first_vld",  32'(a_vld[2]),  1);
        chk("cont_stays_busy", 32'(a_busy[2]), 1);
        drive(0, 1, 0, 0, 0); drive(0, 1, 1, 0, 0); drive(0, 1, 0, 0, 0); drive(0, 1, 1, 0, 0);
        chk("cont_drop_dout", 32'(a_dout[2]), 32'hA);
        chk("cont_drop_vld",  32'(a_vld[2]),  1);
        chk("cont_drop_ovr",  32'(a_ovr[2]),  1);
        drive(0, 0, 0, 0, 1);
        chk("cont_clr_ovr", 32'(a_ovr[2]), 0);
        chk("cont_clr_keeps_dout", 32'(a_dout[2]), 32'hA);
        drive(0, 1, 0, 0, 0); drive(0, 1, 0, 0, 0); drive(0, 1, 1, 0, 0);
        chk("cont_hold_dout", 32'(a_dout[2]), 32'hA);
        drive(0, 1, 1, 1, 0);
        chk("cont_swap_dout", 32'(a_dout[2]), 32'h3);
        chk("cont_swap_vld",  32'(a_vld[2]),  1);
        chk("cont_swap_ovr",  32'(a_ovr[2]),  0);

        // Reset mid-frame with a word pending
        do_reset();
        drive(1, 1, 1, 0, 0); drive(0, 1, 1, 0, 0); drive(0, 1, 0, 0, 0); drive(0, 1, 0, 0, 0);
        chk("pend_dout", 32'(a_dout[0]), 32'hC);
        chk("pend_vld",  32'(a_vld[0]),  1);
        drive(1, 1, 1, 0, 0); drive(0, 1, 1, 0, 0);
        chk("pend_cnt", 32'(a_cnt[0]), 2);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("async_dout[%0d]", i), 32'(a_dout[i]), 0);
            chk($sformatf("async_vld[%0d]", i),  32'(a_vld[i]),  0);
            chk($sformatf("async_cnt[%0d]", i),  32'(a_cnt[i]),  0);
            chk($sformatf("async_busy[%0d]", i), 32'(a_busy[i]), 0);
        end
        #1;
        rst_n = 1'b1;
        drive(1, 1, 1, 0, 0); drive(0, 1, 1, 0, 0); drive(0, 1, 1, 0, 0); drive(0, 1, 1, 0, 0);
        chk("after_reset_dout", 32'(a_dout[0]), 32'hF);
        chk("after_reset_vld",  32'(a_vld[0]),  1);

        // Random phase, all instances against the model
        do_reset();
        for (int c = 0; c < 600; c++) begin
            drive($urandom_range(0, 9) == 0, $urandom_range(0, 9) < 7, 1'($urandom),
                  $urandom_range(0, 1) == 1, $urandom_range(0, 19) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
